// File: rtl/counter_sched.sv
// Two-requester round-robin scheduler that drives a 4-bit counter for LEN enabled
// cycles per job and reports how many ripple-carry events the job produced.
module counter_sched (
  input  logic       clk,
  input  logic       RESET,
  input  logic       A_VALID,
  input  logic       B_VALID,
  input  logic [1:0] A_MODO,
  input  logic [1:0] B_MODO,
  input  logic [3:0] A_D,
  input  logic [3:0] B_D,
  input  logic [3:0] A_LEN,
  input  logic [3:0] B_LEN,
  output logic       A_READY,
  output logic       B_READY,
  input  logic       ABORT,
  input  logic       CNT_RCO,
  output logic       CNT_ENABLE,
  output logic [1:0] CNT_MODO,
  output logic [3:0] CNT_D,
  output logic       DONE_A,
  output logic       DONE_B,
  output logic       ABORTED,
  output logic [4:0] WRAPS,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;      // 0 = A has priority, 1 = B
  logic       owner_q, owner_d;  // 0 = A owns the job, 1 = B
  logic [1:0] modo_q, modo_d;
  logic [3:0] d_q, d_d;
  logic [4:0] rem_q, rem_d;
  logic       first_q, first_d;
  logic [4:0] rco_cnt_q, rco_cnt_d;
  logic [4:0] wraps_q, wraps_d;
  logic       grant_a, grant_b;

  function automatic logic [4:0] len_to_cnt(input logic [3:0] len);
    len_to_cnt = (len == 4'd0) ? 5'd16 : {1'b0, len};
  endfunction

  // READY is combinational; gating on RESET keeps it low while reset is held
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (RESET && state_q == IDLE) begin
      if (A_VALID && B_VALID) begin
        grant_a = ~ptr_q;
        grant_b = ptr_q;
      end else begin
        grant_a = A_VALID;
        grant_b = B_VALID;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    modo_d    = modo_q;
    d_d       = d_q;
    rem_d     = rem_q;
    first_d   = first_q;
    rco_cnt_d = rco_cnt_q;
    wraps_d   = wraps_q;
    case (state_q)
      IDLE: begin
        if (grant_a || grant_b) begin
          state_d   = RUN;
          owner_d   = grant_b;
          ptr_d     = ~grant_b;
          modo_d    = grant_b ? B_MODO : A_MODO;
          d_d       = grant_b ? B_D : A_D;
          rem_d     = len_to_cnt(grant_b ? B_LEN : A_LEN);
          first_d   = 1'b1;
          rco_cnt_d = 5'd0;
        end
      end
      RUN: begin
        if (ABORT) begin
          state_d = IDLE;
        end else begin
          rem_d   = rem_q - 5'd1;
          first_d = 1'b0;
          // RCO lags the enable by one cycle, so the first RUN cycle has nothing to count
          if (!first_q) rco_cnt_d = rco_cnt_q + {4'd0, CNT_RCO};
          if (rem_q == 5'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        if (!ABORT) wraps_d = rco_cnt_q + {4'd0, CNT_RCO};
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      modo_q    <= 2'd0;
      d_q       <= 4'd0;
      rem_q     <= 5'd0;
      first_q   <= 1'b0;
      rco_cnt_q <= 5'd0;
      wraps_q   <= 5'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      modo_q    <= modo_d;
      d_q       <= d_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      rco_cnt_q <= rco_cnt_d;
      wraps_q   <= wraps_d;
    end
  end

  always_comb begin
    A_READY    = grant_a;
    B_READY    = grant_b;
    CNT_ENABLE = 1'b0;
    CNT_MODO   = 2'd0;
    CNT_D      = 4'd0;
    DONE_A     = 1'b0;
    DONE_B     = 1'b0;
    ABORTED    = 1'b0;
    BUSY       = (state_q == RUN) || (state_q == DRAIN);
    WRAPS      = wraps_q;
    if (state_q == RUN) begin
      CNT_ENABLE = 1'b1;
      CNT_MODO   = modo_q;
      CNT_D      = d_q;
    end
    // a cancel landing on the drain cycle suppresses the completion pulse
    if (state_q == DRAIN && !ABORT) begin
      DONE_A = ~owner_q;
      DONE_B = owner_q;
    end
    if (BUSY && ABORT) ABORTED = 1'b1;
  end

endmodule
